// File: rtl/io_read_queue.sv
// io_read_queue: CPU read queue fed by the local I/O devices.
//
// Each writing device (0 = locker, 1 = messenger, ...) lands its 32-bit result
// in its own skid register. One skid per cycle drains into a first-word
// fall-through FIFO. The lowest index always wins the drain. The CPU pops the
// FIFO head to complete an I/O read.
//
// Ports:
//   clock       system clock
//   reset       asynchronous, active-high reset
//   wrq         per-source write strobe
//   rqIn        per-source data, source i at [32*i+31:32*i]
//   rqBusy      per-source skid occupied (device must hold off)
//   rdRQ        pop the head entry
//   rq          head entry (registered, first-word fall-through)
//   rqEmpty     FIFO has no valid head
//   rqCount     entries in the FIFO, skids excluded
//   rqOverflow  sticky: a write arrived while its skid was held and was dropped
//
// Build option: RQ_BYPASS_EN. When this macro is defined and the queue is
// completely idle (FIFO empty, no skid valid), the highest-priority writer goes
// straight into the head. This gives a latency of one cycle instead of two.

module io_read_queue #(
  parameter int NSRC       = 4,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NSRC-1:0]       wrq,
  input  logic [32*NSRC-1:0]    rqIn,
  output logic [NSRC-1:0]       rqBusy,
  input  logic                  rdRQ,
  output logic [31:0]           rq,
  output logic                  rqEmpty,
  output logic [DEPTH_LOG2:0]   rqCount,
  output logic                  rqOverflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] PTR_ONE  = (DEPTH_LOG2 + 1)'(1);

  logic [31:0]         skid_data [NSRC];
  logic [NSRC-1:0]     skid_vld;
  logic [31:0]         mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic [DEPTH_LOG2:0] count;
  logic [31:0]         head;
  logic                overflow;

  logic                empty;
  logic                full;
  logic                pop;
  logic                push;
  logic                found;
  logic [NSRC-1:0]     drain_sel;
  logic [NSRC-1:0]     byp_sel;
  logic [31:0]         push_data;
  logic [DEPTH_LOG2:0] pop_ext;
  logic [DEPTH_LOG2:0] push_ext;
  logic [DEPTH_LOG2:0] cnt_next;
  logic [DEPTH_LOG2:0] rd_next;
  logic [31:0]         head_next;

  always_comb begin
    empty     = (count == '0);
    full      = (count == FULL_CNT);
    pop       = rdRQ && !empty;
    drain_sel = '0;
    byp_sel   = '0;
    push_data = '0;
    found     = 1'b0;
    push      = 1'b0;

    // Lowest-index valid skid is the drain candidate.
    for (int i = 0; i < NSRC; i++) begin
      if (skid_vld[i] && !found) begin
        found        = 1'b1;
        drain_sel[i] = 1'b1;
        push_data    = skid_data[i];
      end
    end

    // A full FIFO still accepts the drain if the head leaves this cycle.
    push = found && (!full || pop);
    if (!push) begin
      drain_sel = '0;
    end

`ifdef RQ_BYPASS_EN
    if (empty && (skid_vld == '0)) begin
      for (int i = 0; i < NSRC; i++) begin
        if (wrq[i] && !push) begin
          byp_sel[i] = 1'b1;
          push       = 1'b1;
          push_data  = rqIn[32*i +: 32];
        end
      end
    end
`endif

    pop_ext  = {{DEPTH_LOG2{1'b0}}, pop};
    push_ext = {{DEPTH_LOG2{1'b0}}, push};
    cnt_next = count + push_ext - pop_ext;
    rd_next  = rd_ptr + pop_ext;

    // The head register always holds the entry that rd_ptr will point at.
    // The pushed word becomes the head when nothing older survives this cycle.
    // Otherwise the new head is already in memory.
    if (push && ((count - pop_ext) == '0)) begin
      head_next = push_data;
    end else if (cnt_next != '0) begin
      head_next = mem[rd_next[DEPTH_LOG2-1:0]];
    end else begin
      head_next = head;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head     <= '0;
      skid_vld <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < NSRC; i++) begin
        skid_data[i] <= '0;
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      rd_ptr <= rd_next;
      count  <= cnt_next;
      head   <= head_next;
      for (int i = 0; i < NSRC; i++) begin
        if (wrq[i] && !byp_sel[i]) begin
          // A skid that drains this cycle is free to recapture.
          if (!skid_vld[i] || drain_sel[i]) begin
            skid_vld[i]  <= 1'b1;
            skid_data[i] <= rqIn[32*i +: 32];
          end else begin
            overflow <= 1'b1;
          end
        end else if (drain_sel[i]) begin
          skid_vld[i] <= 1'b0;
        end
      end
    end
  end

  assign rq         = head;
  assign rqEmpty    = empty;
  assign rqCount    = count;
  assign rqBusy     = skid_vld;
  assign rqOverflow = overflow;

endmodule

// File: tb/tb_io_read_queue.sv
// Testbench for io_read_queue. Outputs are compared against a queue-level
// model of the skids and the FIFO after every clock edge.
module tb_io_read_queue;
  localparam int NSRC  = 4;
  localparam int DL    = 4;
  localparam int DEPTH = 16;
`ifdef RQ_BYPASS_EN
  localparam int LAT       = 1;
  localparam int BUSY_PAIR = 1;
`else
  localparam int LAT       = 2;
  localparam int BUSY_PAIR = 2;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NSRC-1:0]   wrq = '0;
  logic [32*NSRC-1:0] rqIn = '0;
  logic [NSRC-1:0]   rqBusy;
  logic              rdRQ = 1'b0;
  logic [31:0]       rq;
  logic              rqEmpty;
  logic [DL:0]       rqCount;
  logic              rqOverflow;

  int checks = 0;
  int errors = 0;

  logic [31:0]     mq[$];
  logic [31:0]     m_skid [NSRC];
  logic [NSRC-1:0] m_vld;
  logic            m_ovf;

  io_read_queue #(.NSRC(NSRC), .DEPTH_LOG2(DL)) dut (
    .clock(clock), .reset(reset), .wrq(wrq), .rqIn(rqIn), .rqBusy(rqBusy),
    .rdRQ(rdRQ), .rq(rq), .rqEmpty(rqEmpty), .rqCount(rqCount),
    .rqOverflow(rqOverflow)
  );

  always #5 clock = ~clock;

  task automatic model_clear();
    mq.delete();
    m_vld = '0;
    m_ovf = 1'b0;
    for (int i = 0; i < NSRC; i++) m_skid[i] = '0;
  endtask

  // One active edge: the model takes the inputs present at the edge, then
  // sampling happens 1 time unit later.
  task automatic step();
    logic pop, drain;
    int d, b;
    @(posedge clock);
    pop = rdRQ && (mq.size() != 0);
    d = -1;
    for (int i = 0; i < NSRC; i++) if (m_vld[i] && d < 0) d = i;
    drain = (d >= 0) && ((mq.size() < DEPTH) || pop);
    b = -1;
`ifdef RQ_BYPASS_EN
    if (mq.size() == 0 && m_vld == '0)
      for (int i = 0; i < NSRC; i++) if (wrq[i] && b < 0) b = i;
`endif
    if (pop) void'(mq.pop_front());
    if (drain) mq.push_back(m_skid[d]);
    if (b >= 0) mq.push_back(rqIn[32*b +: 32]);
    for (int i = 0; i < NSRC; i++) begin
      if (wrq[i] && i != b) begin
        if (!m_vld[i] || (drain && d == i)) begin
          m_vld[i]  = 1'b1;
          m_skid[i] = rqIn[32*i +: 32];
        end else begin
          m_ovf = 1'b1;
        end
      end else if (drain && d == i) begin
        m_vld[i] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (rqBusy !== 4'b0) begin errors++; $display("FAIL reset_busy got %b want 0000", rqBusy); end
    checks++; if (rq !== 32'h0) begin errors++; $display("FAIL reset_rq got %h want 00000000", rq); end
    checks++; if (rqEmpty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", rqEmpty); end
    checks++; if (rqCount !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", rqCount); end
    checks++; if (rqOverflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", rqOverflow); end
    @(posedge clock); #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_single();
    wrq = 4'b0001; rqIn[31:0] = 32'h1;
    step();
    wrq = '0;
    for (int k = 1; k < LAT; k++) begin
      checks++; if (rqEmpty !== 1'b1) begin errors++; $display("FAIL single_early got empty=%b want 1", rqEmpty); end
      step();
    end
    checks++; if (rqEmpty !== 1'b0) begin errors++; $display("FAIL single_empty got %b want 0", rqEmpty); end
    checks++; if (rq !== 32'h1) begin errors++; $display("FAIL single_rq got %h want 00000001", rq); end
    checks++; if (rqCount !== 5'd1) begin errors++; $display("FAIL single_count got %0d want 1", rqCount); end
    rdRQ = 1'b1; step(); rdRQ = 1'b0;
    checks++; if (rqEmpty !== 1'b1) begin errors++; $display("FAIL single_pop_empty got %b want 1", rqEmpty); end
    checks++; if (rqCount !== 5'd0) begin errors++; $display("FAIL single_pop_count got %0d want 0", rqCount); end
  endtask

  task automatic test_pair();
    int busy_cycles;
    busy_cycles = 0;
    wrq = 4'b0011; rqIn[31:0] = 32'h1; rqIn[63:32] = 32'hAAAA5555;
    step();
    wrq = '0;
    if (rqBusy[1]) busy_cycles++;
    for (int k = 0; k < 5; k++) begin
      step();
      if (rqBusy[1]) busy_cycles++;
    end
    checks++; if (busy_cycles != BUSY_PAIR) begin errors++; $display("FAIL pair_busy_len got %0d want %0d", busy_cycles, BUSY_PAIR); end
    checks++; if (rqCount !== 5'd2) begin errors++; $display("FAIL pair_count got %0d want 2", rqCount); end
    checks++; if (rq !== 32'h1) begin errors++; $display("FAIL pair_first got %h want 00000001", rq); end
    rdRQ = 1'b1; step(); rdRQ = 1'b0;
    checks++; if (rq !== 32'hAAAA5555) begin errors++; $display("FAIL pair_second got %h want aaaa5555", rq); end
    rdRQ = 1'b1; step(); rdRQ = 1'b0;
    checks++; if (rqEmpty !== 1'b1) begin errors++; $display("FAIL pair_empty got %b want 1", rqEmpty); end
    checks++; if (rqOverflow !== 1'b0) begin errors++; $display("FAIL pair_ovf got %b want 0", rqOverflow); end
  endtask

  task automatic test_full();
    logic [31:0] last;
    last = '0;
    for (int k = 0; k < 16; k++) begin
      wrq = 4'b0001; rqIn[31:0] = 32'h100 + 32'(k);
      step();
    end
    wrq = '0;
    step();
    checks++; if (rqCount !== 5'd16) begin errors++; $display("FAIL full_count got %0d want 16", rqCount); end
    wrq = 4'b0100; rqIn[95:64] = 32'h77;
    step();
    wrq = '0;
    checks++; if (rqBusy[2] !== 1'b1) begin errors++; $display("FAIL full_skid_busy got %b want 1", rqBusy[2]); end
    step();
    checks++; if (rqBusy[2] !== 1'b1) begin errors++; $display("FAIL full_skid_held got %b want 1", rqBusy[2]); end
    checks++; if (rqCount !== 5'd16) begin errors++; $display("FAIL full_count_held got %0d want 16", rqCount); end
    rdRQ = 1'b1; step(); rdRQ = 1'b0;
    checks++; if (rqCount !== 5'd16) begin errors++; $display("FAIL full_pushpop_count got %0d want 16", rqCount); end
    checks++; if (rqBusy[2] !== 1'b0) begin errors++; $display("FAIL full_skid_drained got %b want 0", rqBusy[2]); end
    checks++; if (rq !== 32'h101) begin errors++; $display("FAIL full_head got %h want 00000101", rq); end
    for (int k = 0; k < 40 && rqEmpty === 1'b0; k++) begin
      checks++; if (rq !== mq[0]) begin errors++; $display("FAIL full_drain_data got %h want %h", rq, mq[0]); end
      last = rq;
      rdRQ = 1'b1; step(); rdRQ = 1'b0;
    end
    checks++; if (last !== 32'h77) begin errors++; $display("FAIL full_last got %h want 00000077", last); end
    checks++; if (rqEmpty !== 1'b1) begin errors++; $display("FAIL full_drain_empty got %b want 1", rqEmpty); end
  endtask

  task automatic test_overflow();
    wrq = 4'b0001; rqIn[31:0] = 32'h11;
    step();
    wrq = 4'b0011; rqIn[31:0] = 32'h12; rqIn[63:32] = 32'h21;
    step();
    checks++; if (rqBusy[1] !== 1'b1) begin errors++; $display("FAIL ovf_busy got %b want 1", rqBusy[1]); end
    wrq = 4'b0010; rqIn[63:32] = 32'hDEAD;
    step();
    wrq = '0;
    checks++; if (rqOverflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", rqOverflow); end
    for (int k = 0; k < 4; k++) step();
    for (int k = 0; k < 20 && rqEmpty === 1'b0; k++) begin
      checks++; if (rq === 32'hDEAD) begin errors++; $display("FAIL ovf_dropped_seen got %h want not 0000dead", rq); end
      checks++; if (rq !== mq[0]) begin errors++; $display("FAIL ovf_data got %h want %h", rq, mq[0]); end
      rdRQ = 1'b1; step(); rdRQ = 1'b0;
    end
    checks++; if (rqOverflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", rqOverflow); end
    checks++; if (rqEmpty !== 1'b1) begin errors++; $display("FAIL ovf_drain_empty got %b want 1", rqEmpty); end
  endtask

  task automatic test_wrap();
    int nw, nr, cyc;
    nw = 0; nr = 0; cyc = 0;
    while (nr < 40 && cyc < 400) begin
      if (nw < 40) begin
        wrq = 4'b0001; rqIn[31:0] = 32'(nw); nw++;
      end else begin
        wrq = '0;
      end
      rdRQ = !rqEmpty && (rqCount > 5'd3 || nw >= 40);
      if (rdRQ) begin
        checks++; if (rq !== 32'(nr)) begin errors++; $display("FAIL wrap_order got %h want %h", rq, 32'(nr)); end
        nr++;
      end
      step();
      cyc++;
    end
    wrq = '0; rdRQ = 1'b0;
    checks++; if (nr != 40) begin errors++; $display("FAIL wrap_timeout got %0d reads want 40", nr); end
    checks++; if (rqCount !== 5'd0) begin errors++; $display("FAIL wrap_final_count got %0d want 0", rqCount); end
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 5; k++) begin
      wrq = 4'b0001; rqIn[31:0] = 32'h500 + 32'(k);
      step();
    end
    wrq = '0;
    step();
    wrq = 4'b0110; rqIn[63:32] = 32'h601; rqIn[95:64] = 32'h602;
    step();
    wrq = '0;
    checks++; if (rqBusy !== m_vld) begin errors++; $display("FAIL mrst_pre_busy got %b want %b", rqBusy, m_vld); end
    reset = 1'b1;
    #2;
    checks++; if (rqEmpty !== 1'b1) begin errors++; $display("FAIL mrst_empty got %b want 1", rqEmpty); end
    checks++; if (rqCount !== 5'd0) begin errors++; $display("FAIL mrst_count got %0d want 0", rqCount); end
    checks++; if (rqBusy !== 4'b0) begin errors++; $display("FAIL mrst_busy got %b want 0000", rqBusy); end
    checks++; if (rqOverflow !== 1'b0) begin errors++; $display("FAIL mrst_ovf got %b want 0", rqOverflow); end
    @(posedge clock); #1;
    reset = 1'b0;
    model_clear();
    wrq = 4'b1000; rqIn[127:96] = 32'hCAFE0003;
    step();
    wrq = '0;
    for (int k = 1; k < LAT; k++) step();
    checks++; if (rqEmpty !== 1'b0) begin errors++; $display("FAIL mrst_after_empty got %b want 0", rqEmpty); end
    checks++; if (rq !== 32'hCAFE0003) begin errors++; $display("FAIL mrst_after_rq got %h want cafe0003", rq); end
    checks++; if (rqCount !== 5'd1) begin errors++; $display("FAIL mrst_after_count got %0d want 1", rqCount); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      wrq = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      for (int i = 0; i < NSRC; i++) rqIn[32*i +: 32] = $urandom;
      rdRQ = 1'($urandom_range(0, 1));
      step();
      checks++; if (rqEmpty !== (mq.size() == 0)) begin errors++; $display("FAIL rand_empty cyc %0d got %b want %b", c, rqEmpty, (mq.size() == 0)); end
      checks++; if (rqCount !== 5'(mq.size())) begin errors++; $display("FAIL rand_count cyc %0d got %0d want %0d", c, rqCount, mq.size()); end
      checks++; if (rqBusy !== m_vld) begin errors++; $display("FAIL rand_busy cyc %0d got %b want %b", c, rqBusy, m_vld); end
      checks++; if (rqOverflow !== m_ovf) begin errors++; $display("FAIL rand_ovf cyc %0d got %b want %b", c, rqOverflow, m_ovf); end
      if (mq.size() != 0) begin
        checks++; if (rq !== mq[0]) begin errors++; $display("FAIL rand_rq cyc %0d got %h want %h", c, rq, mq[0]); end
      end
    end
    wrq = '0; rdRQ = 1'b0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_pair();
    test_full();
    test_overflow();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
